hs_tx_serializer: RTL and testbench

High-speed transmit serializer for the MIPI D-PHY data lane. It takes bytes from the PPI side on a TxRequestHS/TxReadyHS handshake and frames each burst as HS-zero, sync sequence, payload, then trailer. It emits two bits per TxDDRClk cycle on ser_b1/ser_b2, along with the SOT drive enable. Its outputs feed the dual-edge output flip-flop stage directly: ser_b1 is the earlier bit of each pair, ser_b2 the later.

---
 rtl/hs_tx_serializer.sv | 131 +++++++++++++
 tb/tb_hs_tx_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hs_tx_serializer.sv
// D-PHY HS data-lane transmit serializer: HS-zero, sync, payload, trailer.
// Ports: TxDDRClk/TxRst, PPI TxRequestHS/TxDataHS/TxReadyHS, ser_b1/ser_b2 pair, SOT, hs_busy.
module hs_tx_serializer #(
  parameter int HS_ZERO_CYC = 8,
  parameter int TRAIL_CYC   = 4
) (
  input  logic       TxDDRClk,
  input  logic       TxRst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       ser_b1,
  output logic       ser_b2,
  output logic       SOT,
  output logic       hs_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    SYNC,
    DATA,
    TRAIL
  } state_t;

  localparam logic [7:0] ZMAX = 8'(HS_ZERO_CYC - 1);
  localparam logic [7:0] TMAX = 8'(TRAIL_CYC - 1);
  localparam logic [7:0] SYNC_WORD = 8'hB8;

  state_t     state, ns;
  logic [7:0] cnt, ncnt;
  logic [1:0] pc, npc;
  logic [7:0] sh, nsh;
  logic       last, nlast;
  logic       nb1, nb2, nsot, nbusy;
  logic       boundary;

  // last pair of the sync word or of a byte
  assign boundary  = ((state == SYNC) || (state == DATA)) && (pc == 2'd3);
  assign TxReadyHS = boundary & TxRequestHS;

  always_ff @(posedge TxDDRClk or posedge TxRst) begin
    if (TxRst) begin
      state   <= IDLE;
      cnt     <= '0;
      pc      <= '0;
      sh      <= '0;
      last    <= 1'b0;
      ser_b1  <= 1'b0;
      ser_b2  <= 1'b0;
      SOT     <= 1'b0;
      hs_busy <= 1'b0;
    end else begin
      state   <= ns;
      cnt     <= ncnt;
      pc      <= npc;
      sh      <= nsh;
      last    <= nlast;
      ser_b1  <= nb1;
      ser_b2  <= nb2;
      SOT     <= nsot;
      hs_busy <= nbusy;
    end
  end

  always_comb begin
    ns    = state;
    ncnt  = cnt;
    npc   = pc;
    nsh   = sh;
    nlast = last;
    unique case (state)
      IDLE: begin
        if (TxRequestHS) begin
          ns   = ZERO;
          ncnt = '0;
        end
      end
      ZERO: begin
        if (cnt == ZMAX) begin
          ns   = SYNC;
          ncnt = '0;
          npc  = '0;
          nsh  = SYNC_WORD;
        end else begin
          ncnt = cnt + 8'd1;
        end
      end
      SYNC, DATA: begin
        if (pc == 2'd3) begin
          if (TxRequestHS) begin
            ns  = DATA;
            npc = '0;
            nsh = TxDataHS;
          end else begin
            // sh[1] holds bit 7, the final bit on the line
            ns    = TRAIL;
            ncnt  = '0;
            nlast = sh[1];
          end
        end else begin
          npc = pc + 2'd1;
          nsh = {2'b00, sh[7:2]};
        end
      end
      TRAIL: begin
        if (cnt == TMAX) begin
          ns   = IDLE;
          ncnt = '0;
        end else begin
          ncnt = cnt + 8'd1;
        end
      end
      default: ns = IDLE;
    endcase

    // outputs registered from next-state values
    nb1   = 1'b0;
    nb2   = 1'b0;
    nsot  = (ns != IDLE);
    nbusy = (ns != IDLE);
    if ((ns == SYNC) || (ns == DATA)) begin
      nb1 = nsh[0];
      nb2 = nsh[1];
    end else if (ns == TRAIL) begin
      nb1 = ~nlast;
      nb2 = ~nlast;
    end
  end

endmodule

// File: tb/tb_hs_tx_serializer.sv
// Testbench for hs_tx_serializer: per-cycle scoreboard of
// {TxReadyHS, SOT, hs_busy, ser_b1, ser_b2}, two parameter sets.
module tb_hs_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       rdy0, b10, b20, sot0, busy0;
  logic       rdy1, b11, b21, sot1, busy1;

  logic [4:0] q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  bit         sel = 1'b0;

  always #5 clk = ~clk;

  hs_tx_serializer dut (
    .TxDDRClk(clk), .TxRst(rst), .TxRequestHS(req0), .TxDataHS(d0),
    .TxReadyHS(rdy0), .ser_b1(b10), .ser_b2(b20), .SOT(sot0),
    .hs_busy(busy0)
  );

  hs_tx_serializer #(.HS_ZERO_CYC(1), .TRAIL_CYC(1)) dut1 (
    .TxDDRClk(clk), .TxRst(rst), .TxRequestHS(req1), .TxDataHS(d1),
    .TxReadyHS(rdy1), .ser_b1(b11), .ser_b2(b21), .SOT(sot1),
    .hs_busy(busy1)
  );

  function automatic logic [4:0] obs();
    if (sel) return {rdy1, sot1, busy1, b11, b21};
    return {rdy0, sot0, busy0, b10, b20};
  endfunction

  task automatic chk(string tag, logic [4:0] o, logic [4:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic p(logic r, logic s, logic b, logic x1, logic x2);
    q.push_back({r, s, b, x1, x2});
  endtask

  task automatic p_zero(int n);
    repeat (n) p(0, 1, 1, 0, 0);
  endtask

  // sync word 8'hB8 on the line LSB first
  task automatic p_sync(logic r);
    p(0, 1, 1, 0, 0);
    p(0, 1, 1, 0, 1);
    p(0, 1, 1, 1, 1);
    p(r, 1, 1, 0, 1);
  endtask

  task automatic p_byte(logic [7:0] b, logic r);
    for (int k = 0; k < 4; k++)
      p((k == 3) ? r : 1'b0, 1, 1, b[2*k], b[2*k+1]);
  endtask

  task automatic p_trail(int n, logic v);
    repeat (n) p(0, 1, 1, v, v);
  endtask

  task automatic p_idle(int n);
    repeat (n) p(0, 0, 0, 0, 0);
  endtask

  // check the current cycle, then drive inputs for the next edge
  task automatic tick(string tag, logic r, logic [7:0] d);
    @(negedge clk);
    if (q.size() == 0) begin
      n_assert++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s scoreboard empty observed=%b expected=entry",
               tag, obs());
      end
    end else begin
      chk(tag, obs(), q.pop_front());
    end
    if (sel) begin
      req1 = r;
      d1   = d;
    end else begin
      req0 = r;
      d0   = d;
    end
  endtask

  task automatic drained(string tag);
    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s leftover observed=%0d expected=0", tag, q.size());
    end
  endtask

  initial begin
    int n;
    logic [7:0] b2nd;

    // reset state
    #1;
    chk("reset_dut", obs(), 5'b0);
    sel = 1'b1;
    chk("reset_dut1", obs(), 5'b0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p_idle(2);
    tick("idle", 0, 8'h00);
    tick("idle", 1, 8'hA5);

    // single byte A5
    p_zero(8); p_sync(1); p_byte(8'hA5, 0); p_trail(4, 0); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("single_A5", c <= 12, 8'hA5);
    drained("single_A5");

    // back-to-back 00 FF 3C
    p_idle(1);
    tick("idle", 1, 8'h00);
    p_zero(8); p_sync(1);
    p_byte(8'h00, 1); p_byte(8'hFF, 1); p_byte(8'h3C, 0);
    p_trail(4, 1); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("b2b", c <= 20,
           (c <= 12) ? 8'h00 : ((c <= 16) ? 8'hFF : 8'h3C));
    drained("b2b");

    // empty burst
    p_idle(1);
    tick("idle", 1, 8'h00);
    p_zero(8); p_sync(0); p_trail(4, 0); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("empty", 0, 8'h00);
    drained("empty");

    // reset during pair 2 of the second byte
    b2nd = 8'h96;
    p_idle(1);
    tick("idle", 1, 8'h11);
    p_zero(8); p_sync(1); p_byte(8'h11, 1);
    for (int k = 0; k < 3; k++)
      p(0, 1, 1, b2nd[2*k], b2nd[2*k+1]);
    for (int c = 1; c <= 19; c++)
      tick("pre_rst", 1, (c <= 12) ? 8'h11 : 8'h96);
    drained("pre_rst");
    #1 rst = 1'b1;
    #1 chk("rst_async", obs(), 5'b0);
    @(posedge clk);
    #1 chk("rst_hold", obs(), 5'b0);
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1;
    d0   = 8'h5A;
    p_zero(8); p_sync(1); p_byte(8'h5A, 0); p_trail(4, 1); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("post_rst", c <= 12, 8'h5A);
    drained("post_rst");

    // request held high through TRAIL
    p_idle(1);
    tick("idle", 1, 8'hA5);
    p_zero(8); p_sync(1); p_byte(8'hA5, 0); p_trail(4, 0); p_idle(1);
    p_zero(8); p_sync(0); p_trail(4, 0); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("trail_req", (c <= 12) || (c >= 17 && c <= 21), 8'hA5);
    drained("trail_req");

    // short parameters, byte 80
    sel = 1'b1;
    p_idle(1);
    tick("idle1", 1, 8'h80);
    p_zero(1); p_sync(1); p_byte(8'h80, 0); p_trail(1, 0); p_idle(2);
    n = q.size();
    for (int c = 1; c <= n; c++)
      tick("short_80", c <= 5, 8'h80);
    drained("short_80");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
